// File: rtl/window_gen.sv
`default_nettype none
// ============================================================================
// Module      : window_gen
// Description : 3x3 sliding-window generator for raster-order 8-bit pixels.
//               Two line buffers hold the previous two lines. A 3x3 register
//               window shifts left on every accepted pixel and feeds a 9-input
//               median sorter directly.
//
// Parameters  : LINE_W   pixels per line  (3..4096)
//               FRAME_H  lines per frame  (3..4096)
//
// Ports       : clk              rising-edge clock
//               rst              asynchronous reset, active low
//               sof              start of frame; restarts col/row at (0,0)
//               pixel_in[7:0]    raster-order pixel
//               pixel_in_valid   pixel_in accepted this edge (no backpressure)
//               pixel_out0..8    registered window, row-major
//                                (0 = top-left/oldest, 8 = bottom-right/newest)
//               window_valid     one-cycle strobe: pixel_out0..8 hold a new
//                                complete window
//               frame_done       one-cycle strobe after the last pixel of a
//                                frame is accepted
//
// Revision    : 1.0  initial release
// ============================================================================
module window_gen #(
    parameter int LINE_W  = 640,
    parameter int FRAME_H = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sof,
    input  logic [7:0] pixel_in,
    input  logic       pixel_in_valid,
    output logic [7:0] pixel_out0,
    output logic [7:0] pixel_out1,
    output logic [7:0] pixel_out2,
    output logic [7:0] pixel_out3,
    output logic [7:0] pixel_out4,
    output logic [7:0] pixel_out5,
    output logic [7:0] pixel_out6,
    output logic [7:0] pixel_out7,
    output logic [7:0] pixel_out8,
    output logic       window_valid,
    output logic       frame_done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_col_w = (LINE_W  > 1) ? $clog2(LINE_W)  : 1;
    localparam int c_row_w = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;

    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(LINE_W - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(FRAME_H - 1);
    // A window is complete once two earlier columns and two earlier lines
    // exist in the current frame.
    localparam logic [c_col_w-1:0] c_col_min  = c_col_w'(2);
    localparam logic [c_row_w-1:0] c_row_min  = c_row_w'(2);

    // ------------------------------------------------------------------------
    // Position counters
    // ------------------------------------------------------------------------
    logic [c_col_w-1:0] r_col;
    logic [c_row_w-1:0] r_row;

    logic [c_col_w-1:0] w_col_cur;
    logic [c_row_w-1:0] w_row_cur;
    logic [c_col_w-1:0] w_col_nxt;
    logic [c_row_w-1:0] w_row_nxt;
    logic               w_last_col;
    logic               w_last_row;

    // sof overrides the stored position before the accept, so a pixel that
    // arrives together with sof is treated as (row 0, col 0).
    always_comb begin
        w_col_cur  = sof ? '0 : r_col;
        w_row_cur  = sof ? '0 : r_row;
        w_last_col = (w_col_cur == c_col_last);
        w_last_row = (w_row_cur == c_row_last);
        w_col_nxt  = w_col_cur;
        w_row_nxt  = w_row_cur;
        if (pixel_in_valid) begin
            if (w_last_col) begin
                w_col_nxt = '0;
                if (w_last_row) begin
                    w_row_nxt = '0;
                end else begin
                    w_row_nxt = w_row_cur + 1'b1;
                end
            end else begin
                w_col_nxt = w_col_cur + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Line buffers
    //   r_lb1 : previous line
    //   r_lb0 : line before that
    // Both are read at the current column and rewritten in the same cycle:
    // the old previous-line pixel moves down into r_lb0 and the new pixel
    // lands in r_lb1. Contents are not reset; the window_valid qualification
    // guarantees stale data never appears in a valid window.
    // ------------------------------------------------------------------------
    logic [7:0] r_lb0 [0:LINE_W-1];
    logic [7:0] r_lb1 [0:LINE_W-1];

    logic [7:0] w_lb0_rd;
    logic [7:0] w_lb1_rd;

    always_comb begin
        w_lb0_rd = r_lb0[w_col_cur];
        w_lb1_rd = r_lb1[w_col_cur];
    end

    always_ff @(posedge clk) begin
        if (pixel_in_valid) begin
            r_lb0[w_col_cur] <= w_lb1_rd;
            r_lb1[w_col_cur] <= pixel_in;
        end
    end

    // ------------------------------------------------------------------------
    // 3x3 window registers
    // Each row shifts left by one on accept; the rightmost column takes the
    // two line-buffer reads (top, middle) and the incoming pixel (bottom).
    // Registers shift across line wraps too; those windows are simply not
    // flagged valid.
    // ------------------------------------------------------------------------
    logic [7:0] r_win [0:8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
        end else if (pixel_in_valid) begin
            // top row: oldest line
            r_win[0] <= r_win[1];
            r_win[1] <= r_win[2];
            r_win[2] <= w_lb0_rd;
            // middle row: previous line
            r_win[3] <= r_win[4];
            r_win[4] <= r_win[5];
            r_win[5] <= w_lb1_rd;
            // bottom row: current line
            r_win[6] <= r_win[7];
            r_win[7] <= r_win[8];
            r_win[8] <= pixel_in;
        end
    end

    // ------------------------------------------------------------------------
    // Strobes
    // Both are decoded from the pre-increment position of the accepted pixel
    // and registered, so they line up with the window update.
    // ------------------------------------------------------------------------
    logic w_window_ok;
    logic w_frame_end;

    always_comb begin
        w_window_ok = pixel_in_valid &&
                      (w_row_cur >= c_row_min) &&
                      (w_col_cur >= c_col_min);
        w_frame_end = pixel_in_valid && w_last_row && w_last_col;
    end

    logic r_window_valid;
    logic r_frame_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_window_valid <= w_window_ok;
            r_frame_done   <= w_frame_end;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign pixel_out0   = r_win[0];
    assign pixel_out1   = r_win[1];
    assign pixel_out2   = r_win[2];
    assign pixel_out3   = r_win[3];
    assign pixel_out4   = r_win[4];
    assign pixel_out5   = r_win[5];
    assign pixel_out6   = r_win[6];
    assign pixel_out7   = r_win[7];
    assign pixel_out8   = r_win[8];
    assign window_valid = r_window_valid;
    assign frame_done   = r_frame_done;

endmodule
`default_nettype wire
